// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state codes, keyboard command bytes,
// default link timing and small constant helpers for counter sizing.
package ps2_pkg;

    // Host transmitter FSM state encoding
    typedef logic [2:0] state_t;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] WAIT_CLK  = 3'd3;
    localparam logic [2:0] SHIFT     = 3'd4;
    localparam logic [2:0] ACK       = 3'd5;
    localparam logic [2:0] WAIT_IDLE = 3'd6;

    // Common keyboard command and response bytes
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // Default timing in 25 MHz clock cycles
    localparam int DEF_INHIBIT_CYC = 2500;    // 100 us clock inhibit
    localparam int DEF_REQ_CYC     = 25;      // data+clock low before clock release
    localparam int DEF_FILT_CYC    = 8;       // glitch filter depth
    localparam int DEF_START_TO    = 375000;  // 15 ms for device to start clocking
    localparam int DEF_FRAME_TO    = 50000;   // 2 ms for the rest of the frame

    // Bits needed for a counter that runs 0 .. n-1
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Largest of three values, used to size a shared timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 pad input: 2-FF synchronizer, FILT_CYC-deep glitch filter and a
// one-cycle strobe on each filtered 1->0 transition. Shared with the receiver.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILT_CYC = DEF_FILT_CYC
) (
    input  logic clk25,
    input  logic rst_n,
    input  logic pad,
    output logic level,
    output logic fall
);

    localparam int CW = cnt_width(FILT_CYC);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pad into the clock domain; idle line level is 1
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], pad};
        end
    end

    // Accept a new level only after FILT_CYC consecutive differing samples
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == CW'(FILT_CYC - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                    fall  <= level;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send,
// shifts a command byte with odd parity and stop on device clock edges and
// checks the device ACK. Lines are open-collector via registered enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
    parameter int REQ_CYC     = DEF_REQ_CYC,
    parameter int FILT_CYC    = DEF_FILT_CYC,
    parameter int START_TO    = DEF_START_TO,
    parameter int FRAME_TO    = DEF_FRAME_TO
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       tx_err_to
);

    // One timer covers inhibit, request and start-timeout phases
    localparam int TW = cnt_width(max3(INHIBIT_CYC, REQ_CYC, START_TO));
    localparam int FW = cnt_width(FRAME_TO);

    state_t        state;
    logic [TW-1:0] timer;
    logic [FW-1:0] frame_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    data;
    logic          parity;

    logic c_level;
    logic c_fall;
    logic d_level;
    logic d_fall_unused;

    logic next_bit_low;
    logic in_frame;
    logic frame_expired;

    ps2_line_filter #(
        .FILT_CYC(FILT_CYC)
    ) u_filt_c (
        .clk25(clk25),
        .rst_n(rst_n),
        .pad  (ps2c_in),
        .level(c_level),
        .fall (c_fall)
    );

    ps2_line_filter #(
        .FILT_CYC(FILT_CYC)
    ) u_filt_d (
        .clk25(clk25),
        .rst_n(rst_n),
        .pad  (ps2d_in),
        .level(d_level),
        .fall (d_fall_unused)
    );

    assign tx_ready      = (state == IDLE);
    assign tx_busy       = (state != IDLE);
    assign in_frame      = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
    assign frame_expired = in_frame && (frame_cnt == FW'(FRAME_TO - 1));

    // Select the drive level for the bit presented on the next falling edge
    always_comb begin
        next_bit_low = 1'b0;
        if ((bit_idx >= 4'd1) && (bit_idx <= 4'd7)) begin
            next_bit_low = ~data[bit_idx[2:0]];
        end else if (bit_idx == 4'd8) begin
            next_bit_low = ~parity;
        end
    end

    // Transfer sequencer; a frame timeout overrides any edge in the same cycle
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            frame_cnt <= '0;
            bit_idx   <= '0;
            data      <= '0;
            parity    <= 1'b0;
            ps2c_oe   <= 1'b0;
            ps2d_oe   <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
            tx_err_to <= 1'b0;
        end else begin
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
            tx_err_to <= 1'b0;

            if (frame_expired) begin
                tx_err    <= 1'b1;
                tx_err_to <= 1'b1;
                ps2c_oe   <= 1'b0;
                ps2d_oe   <= 1'b0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        timer     <= '0;
                        frame_cnt <= '0;
                        bit_idx   <= '0;
                        ps2c_oe   <= 1'b0;
                        ps2d_oe   <= 1'b0;
                        if (tx_valid) begin
                            data    <= tx_data;
                            parity  <= ~^tx_data;
                            ps2c_oe <= 1'b1;
                            state   <= INHIBIT;
                        end
                    end

                    INHIBIT: begin
                        if (timer == TW'(INHIBIT_CYC - 1)) begin
                            timer   <= '0;
                            ps2d_oe <= 1'b1;
                            state   <= REQ;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end

                    REQ: begin
                        if (timer == TW'(REQ_CYC - 1)) begin
                            timer   <= '0;
                            ps2c_oe <= 1'b0;
                            state   <= WAIT_CLK;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end

                    WAIT_CLK: begin
                        if (c_fall) begin
                            ps2d_oe   <= ~data[0];
                            bit_idx   <= 4'd1;
                            timer     <= '0;
                            frame_cnt <= '0;
                            state     <= SHIFT;
                        end else if (timer == TW'(START_TO - 1)) begin
                            tx_err    <= 1'b1;
                            tx_err_to <= 1'b1;
                            ps2c_oe   <= 1'b0;
                            ps2d_oe   <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end

                    SHIFT: begin
                        frame_cnt <= frame_cnt + FW'(1);
                        if (c_fall) begin
                            ps2d_oe <= next_bit_low;
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx == 4'd9) begin
                                state <= ACK;
                            end
                        end
                    end

                    ACK: begin
                        frame_cnt <= frame_cnt + FW'(1);
                        if (c_fall) begin
                            if (!d_level) begin
                                state <= WAIT_IDLE;
                            end else begin
                                tx_err  <= 1'b1;
                                ps2c_oe <= 1'b0;
                                ps2d_oe <= 1'b0;
                                state   <= IDLE;
                            end
                        end
                    end

                    WAIT_IDLE: begin
                        frame_cnt <= frame_cnt + FW'(1);
                        if (c_level && d_level) begin
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end
                    end

                    default: begin
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device that clocks
// frames, samples bits on rising edges and drives ACK/NACK.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT_CYC = 2500;
    localparam int REQ_CYC     = 25;
    localparam int FILT_CYC    = 8;
    localparam int START_TO    = 3000;
    localparam int FRAME_TO    = 2000;
    localparam int HALF        = 40;

    logic       clk25 = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       dev_c;
    logic       dev_d;
    logic       ps2c_oe, ps2d_oe;
    logic       tx_ready, tx_busy, tx_done, tx_err, tx_err_to;
    logic       ps2c_line, ps2d_line;

    int checks = 0;
    int errors = 0;

    int         done_cnt  = 0;
    int         err_cnt   = 0;
    int         start_cnt = 0;
    logic       last_err_to = 1'b0;
    logic [1:0] last_oe     = 2'b00;
    logic       prev_c_oe   = 1'b0;

    always #20 clk25 = ~clk25;

    assign ps2c_line = dev_c & ~ps2c_oe;
    assign ps2d_line = dev_d & ~ps2d_oe;

    ps2_host_tx #(
        .INHIBIT_CYC(INHIBIT_CYC),
        .REQ_CYC    (REQ_CYC),
        .FILT_CYC   (FILT_CYC),
        .START_TO   (START_TO),
        .FRAME_TO   (FRAME_TO)
    ) dut (
        .clk25    (clk25),
        .rst_n    (rst_n),
        .ps2c_in  (ps2c_line),
        .ps2d_in  (ps2d_line),
        .ps2c_oe  (ps2c_oe),
        .ps2d_oe  (ps2d_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err),
        .tx_err_to(tx_err_to)
    );

    // Count result pulses and frame starts for later comparison
    always @(negedge clk25) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err) begin
            err_cnt     <= err_cnt + 1;
            last_err_to <= tx_err_to;
            last_oe     <= {ps2c_oe, ps2d_oe};
        end
        if (ps2c_oe && !prev_c_oe) start_cnt <= start_cnt + 1;
        prev_c_oe <= ps2c_oe;
    end

    // Hard stop in case a wait escapes its bound
    initial begin
        #(40 * 200000);
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input bit hold);
        tx_data  = data;
        tx_valid = 1'b1;
        if (!hold) begin
            tick(1);
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_request(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            if (ps2c_oe === 1'b0 && ps2d_oe === 1'b1) seen = 1'b1;
            else tick(1);
        end
    endtask

    task automatic wait_ready(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            if (tx_ready === 1'b1) seen = 1'b1;
            else tick(1);
        end
    endtask

    // Device clocks n_falls edges, sampling PS2D on each rising edge
    task automatic device_frame(input int n_falls, input bit ack_low,
                                input int glitch_after, output logic [9:0] bits);
        bits = '0;
        tick(20);
        for (int i = 0; i < n_falls; i++) begin
            dev_c = 1'b0;
            tick(HALF);
            dev_c = 1'b1;
            if (i < 10) bits[i] = ps2d_line;
            if (i == 9 && ack_low) dev_d = 1'b0;
            if (i == glitch_after) begin
                tick(10);
                dev_c = 1'b0;
                tick(3);
                dev_c = 1'b1;
                tick(HALF - 13);
            end else begin
                tick(HALF);
            end
        end
        dev_d = 1'b1;
    endtask

    task automatic send_ack(input logic [7:0] data, input bit hold, input int glitch_after,
                            input logic [9:0] exp_bits, input string tag);
        int d0, e0, s0;
        bit seen;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        s0 = start_cnt;
        apply_stimulus(data, hold);
        wait_request(seen);
        check_output({tag, "_req"}, 32'(seen), 32'd1);
        device_frame(11, 1'b1, glitch_after, bits);
        tx_valid = 1'b0;
        check_output({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        wait_ready(seen);
        check_output({tag, "_idle"}, 32'(seen), 32'd1);
        tick(3);
        check_output({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check_output({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
        check_output({tag, "_starts"}, 32'(start_cnt - s0), 32'd1);
    endtask

    initial begin
        int cnt;
        int d0, e0;
        bit seen;
        logic [9:0] bits;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_c    = 1'b1;
        dev_d    = 1'b1;
        tick(5);
        check_output("rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
        check_output("rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
        check_output("rst_busy", 32'(tx_busy), 32'd0);
        check_output("rst_ready", 32'(tx_ready), 32'd1);
        check_output("rst_done", 32'(tx_done), 32'd0);
        check_output("rst_err", 32'(tx_err), 32'd0);
        check_output("rst_err_to", 32'(tx_err_to), 32'd0);
        rst_n = 1'b1;
        tick(FILT_CYC + 5);

        // 0xED: inhibit and request timing, then an ACKed frame
        d0 = done_cnt;
        apply_stimulus(CMD_SET_LED, 1'b0);
        check_output("ed_busy", 32'(tx_busy), 32'd1);
        check_output("ed_ready", 32'(tx_ready), 32'd0);
        check_output("ed_inh_c", 32'(ps2c_oe), 32'd1);
        check_output("ed_inh_d", 32'(ps2d_oe), 32'd0);
        cnt = 0;
        while (ps2d_oe !== 1'b1 && cnt < 10000) begin
            tick(1);
            cnt++;
        end
        check_output("ed_inhibit_len", 32'(cnt), 32'(INHIBIT_CYC));
        check_output("ed_req_c", 32'(ps2c_oe), 32'd1);
        cnt = 0;
        while (ps2c_oe !== 1'b0 && cnt < 1000) begin
            tick(1);
            cnt++;
        end
        check_output("ed_req_len", 32'(cnt), 32'(REQ_CYC));
        check_output("ed_start_bit", 32'(ps2d_oe), 32'd1);
        device_frame(11, 1'b1, -1, bits);
        check_output("ed_bits", 32'(bits), 32'h3ED);
        wait_ready(seen);
        check_output("ed_idle", 32'(seen), 32'd1);
        tick(3);
        check_output("ed_done", 32'(done_cnt - d0), 32'd1);

        // Parity variants; 0xF4 is sent with tx_valid held during the frame
        send_ack(CMD_ENABLE, 1'b1, -1, 10'h2F4, "f4_hold");
        send_ack(CMD_RESET, 1'b0, -1, 10'h3FF, "ff");
        send_ack(8'h00, 1'b0, -1, 10'h300, "zero");

        // 3-cycle PS2C glitch after the 4th rising edge must not advance a bit
        send_ack(CMD_SET_LED, 1'b0, 3, 10'h3ED, "glitch");

        // Device NACK: PS2D left high at the 11th fall
        d0 = done_cnt;
        e0 = err_cnt;
        apply_stimulus(CMD_ENABLE, 1'b0);
        wait_request(seen);
        check_output("nack_req", 32'(seen), 32'd1);
        device_frame(11, 1'b0, -1, bits);
        check_output("nack_bits", 32'(bits), 32'h2F4);
        wait_ready(seen);
        tick(3);
        check_output("nack_err", 32'(err_cnt - e0), 32'd1);
        check_output("nack_err_to", 32'(last_err_to), 32'd0);
        check_output("nack_oe", 32'(last_oe), 32'd0);
        check_output("nack_done", 32'(done_cnt - d0), 32'd0);

        // Device never clocks: start timeout after exactly START_TO cycles
        apply_stimulus(CMD_SET_LED, 1'b0);
        wait_request(seen);
        check_output("sto_req", 32'(seen), 32'd1);
        cnt = 0;
        while (tx_err !== 1'b1 && cnt < START_TO + 100) begin
            tick(1);
            cnt++;
        end
        check_output("sto_len", 32'(cnt), 32'(START_TO));
        check_output("sto_err_to", 32'(tx_err_to), 32'd1);
        check_output("sto_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
        check_output("sto_ready", 32'(tx_ready), 32'd1);
        tick(1);
        check_output("sto_ready_next", 32'(tx_ready), 32'd1);
        check_output("sto_err_pulse", 32'(tx_err), 32'd0);

        // Device stops after 5 falls: frame timeout
        d0 = done_cnt;
        apply_stimulus(CMD_ENABLE, 1'b0);
        wait_request(seen);
        check_output("fto_req", 32'(seen), 32'd1);
        device_frame(5, 1'b1, -1, bits);
        cnt = 0;
        while (tx_err !== 1'b1 && cnt < FRAME_TO) begin
            tick(1);
            cnt++;
        end
        check_output("fto_seen", 32'(tx_err), 32'd1);
        check_output("fto_err_to", 32'(tx_err_to), 32'd1);
        check_output("fto_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
        tick(3);
        check_output("fto_done", 32'(done_cnt - d0), 32'd0);

        // Reset during SHIFT releases both lines at once with no pulse
        d0 = done_cnt;
        e0 = err_cnt;
        apply_stimulus(8'h00, 1'b0);
        wait_request(seen);
        check_output("rsh_req", 32'(seen), 32'd1);
        device_frame(3, 1'b1, -1, bits);
        check_output("rsh_pre_d", 32'(ps2d_oe), 32'd1);
        check_output("rsh_pre_busy", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check_output("rsh_c_oe", 32'(ps2c_oe), 32'd0);
        check_output("rsh_d_oe", 32'(ps2d_oe), 32'd0);
        check_output("rsh_busy", 32'(tx_busy), 32'd0);
        check_output("rsh_ready", 32'(tx_ready), 32'd1);
        rst_n = 1'b1;
        tick(20);
        check_output("rsh_no_err", 32'(err_cnt - e0), 32'd0);
        check_output("rsh_no_done", 32'(done_cnt - d0), 32'd0);

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter; the write direction of the PS/2 link alongside the keyboard receiver. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard:
- inhibits the clock, issues a request-to-send, then shifts 8 data bits, odd parity and stop on device-generated clock edges, and checks the device ACK.
- drives open-collector lines via output-enables; the top level converts these to tri-state pads.
- exposes tx_busy so the receiver can ignore frames while a transmit is in progress.

Parameters:
INHIBIT_CYC, 2500, clk25 cycles PS2C is held low before the request (100 us at 25 MHz)
REQ_CYC, 25, cycles PS2D and PS2C are both held low before PS2C is released
FILT_CYC, 8, consecutive equal samples required to accept a new filtered PS2C/PS2D level
START_TO, 375000, max cycles from PS2C release to first falling edge (15 ms)
FRAME_TO, 50000, max cycles from first falling edge to ACK sampled (2 ms)

Ports:
clk25  in  1  system clock, 25 MHz
rst_n  in  1  synchronous reset, active-low
ps2c_in  in  1  raw PS2C pad level (asynchronous)
ps2d_in  in  1  raw PS2D pad level (asynchronous)
ps2c_oe  out  1  1 = drive PS2C low, 0 = release
ps2d_oe  out  1  1 = drive PS2D low, 0 = release
tx_data  in  8  command byte, sampled on accept
tx_valid  in  1  request to send
tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid & tx_ready
tx_busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse: frame sent and ACK received (PS2D low at 11th falling edge)
tx_err  out  1  one-cycle pulse: NACK or timeout; coincides with return to IDLE
tx_err_to  out  1  qualifies tx_err: 1 = timeout, 0 = NACK

Behaviour:
- Reset (rst_n low at a clk25 edge) takes effect at that edge:
  - ps2c_oe=0, ps2d_oe=0, tx_busy=0, tx_ready=1, tx_done=0, tx_err=0, tx_err_to=0.
  - State goes to IDLE and all counters clear.
  - A reset mid-frame releases both lines on that edge; no pulse is issued.
- Input path:
  - Each pad passes through a 2-FF synchronizer, then a glitch filter that changes its output after FILT_CYC equal samples.
  - Filters reset to 1.
  - fall_c is a one-cycle strobe when filtered PS2C goes 1->0.
- Accept: in IDLE with tx_valid=1, latch tx_data and compute parity = ~^tx_data (odd parity). Go to INHIBIT next cycle. tx_valid while busy is ignored.
- INHIBIT: ps2c_oe=1, ps2d_oe=0, held for INHIBIT_CYC cycles, then go to REQ.
- REQ: ps2c_oe=1, ps2d_oe=1 (start bit 0), held for REQ_CYC cycles, then go to WAIT_CLK with ps2c_oe=0. ps2c_oe stays 0 until the next transfer.
- WAIT_CLK:
  - Timeout counter runs from 0.
  - On fall_c, present bit 0 (ps2d_oe = ~tx_data[0]), set bit index to 1, clear the counter and go to SHIFT.
  - If the counter reaches START_TO with no fall_c, raise tx_err with tx_err_to=1, release both lines and go to IDLE.
- SHIFT: on each fall_c, present the next bit:
  - index 1..7 -> data[1..7]
  - index 8 -> parity
  - index 9 -> stop (ps2d_oe=0)
  - After the stop bit is presented, go to ACK.
- ACK: on the next fall_c (11th overall), sample filtered PS2D.
  - 0: ACK; go to WAIT_IDLE.
  - 1: raise tx_err with tx_err_to=0 and go to IDLE.
- WAIT_IDLE: wait until filtered PS2C=1 and PS2D=1, then pulse tx_done and go to IDLE (tx_ready=1 the next cycle).
- Frame timeout: the FRAME_TO counter runs across SHIFT, ACK and WAIT_IDLE. On expiry:
  - tx_err=1, tx_err_to=1, both lines released, go to IDLE.
  - If expiry and fall_c occur in the same cycle, the timeout wins.
- Only one of tx_done and tx_err is ever asserted per transfer. Output-enables are registered; they never glitch.

Decomposition:
- Shared package ps2_pkg holds:
  - State enum: IDLE, INHIBIT, REQ, WAIT_CLK, SHIFT, ACK, WAIT_IDLE.
  - Command constants: CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, RSP_ACK=8'hFA.
  - Default timing constants.
- Sub-module ps2_line_filter (synchronizer + FILT_CYC filter + falling-edge strobe), instantiated twice; the receiver reuses it.

Test Plan:
- Send 0xED with a device model that ACKs:
  - PS2C is low for 2500 cycles, then PS2D goes low.
  - The line sequence after start is 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - PS2D is low at the 11th fall and tx_done pulses once.
- Send 0xF4: parity 0 is presented at index 8; 0xFF: parity 1; 0x00: parity 1. Check each bit against the device model's rising-edge samples.
- Device holds PS2D high at the 11th fall -> tx_err=1, tx_err_to=0, no tx_done, both oe=0.
- Device never clocks -> after exactly START_TO cycles tx_err=1, tx_err_to=1, lines released, tx_ready=1 on the next cycle.
- Device stops clocking after 5 falls -> FRAME_TO expiry error. rst_n=0 during SHIFT -> both oe=0 at that edge and no pulses.
- A 3-cycle glitch on PS2C with FILT_CYC=8 -> no bit advance. tx_valid held high while busy -> exactly one frame sent.
